// File: rtl/lcd_chars_pkg.sv
// lcd_chars_pkg: character codes shared by the LCD/keypad paths, plus the
// classifier and entry-FSM enumerations used by disp2bcd_entry.
package lcd_chars_pkg;

   localparam logic [7:0] CHAR_0            = 8'h30;
   localparam logic [7:0] CHAR_1            = 8'h31;
   localparam logic [7:0] CHAR_2            = 8'h32;
   localparam logic [7:0] CHAR_3            = 8'h33;
   localparam logic [7:0] CHAR_4            = 8'h34;
   localparam logic [7:0] CHAR_5            = 8'h35;
   localparam logic [7:0] CHAR_6            = 8'h36;
   localparam logic [7:0] CHAR_7            = 8'h37;
   localparam logic [7:0] CHAR_8            = 8'h38;
   localparam logic [7:0] CHAR_9            = 8'h39;
   localparam logic [7:0] CHAR_BLANK        = 8'h20;
   localparam logic [7:0] CHAR_HYPHEN_MINUS = 8'h2D;
   localparam logic [7:0] CHAR_ASTERISK     = 8'h2A;
   localparam logic [7:0] CHAR_BACKSPACE    = 8'h08;
   localparam logic [7:0] CHAR_ESCAPE       = 8'h1B;
   localparam logic [7:0] CHAR_CR           = 8'h0D;

   typedef enum logic [2:0] {
      CLS_DIGIT,
      CLS_MINUS,
      CLS_BS,
      CLS_ESC,
      CLS_ENTER,
      CLS_BLANK,
      CLS_BAD
   } char_class_t;

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      HOLD
   } entry_state_t;

endpackage

// File: rtl/disp_char_classify.sv
// disp_char_classify: combinational decode of a character code into its
// entry class and, for digits, the BCD value.
//   char_in    : character code
//   char_cls_c : class (CLS_BAD for anything unrecognised)
//   digit_c    : digit value when class is CLS_DIGIT, else 0
module disp_char_classify
   import lcd_chars_pkg::*;
(
   input  logic [7:0]  char_in,
   output char_class_t char_cls_c,
   output logic [3:0]  digit_c
);

   always_comb begin
      char_cls_c = CLS_BAD;
      digit_c    = 4'd0;
      if ((char_in >= CHAR_0) && (char_in <= CHAR_9)) begin
         char_cls_c = CLS_DIGIT;
         digit_c    = char_in[3:0];
      end else begin
         case (char_in)
            CHAR_HYPHEN_MINUS: char_cls_c = CLS_MINUS;
            CHAR_BACKSPACE:    char_cls_c = CLS_BS;
            CHAR_ESCAPE:       char_cls_c = CLS_ESC;
            CHAR_CR:           char_cls_c = CLS_ENTER;
            CHAR_BLANK:        char_cls_c = CLS_BLANK;
            default:           char_cls_c = CLS_BAD;
         endcase
      end
   end

endmodule

// File: rtl/disp2bcd_entry.sv
// disp2bcd_entry: assembles a signed BCD operand from keyed characters and
// presents it on a valid/ready handshake.
//   clk, rst_n     : clock, synchronous active-low reset
//   char_in/valid  : character stream; char_ready low while an operand is held
//   bcd/sign/count : assembled operand (bcd[0] least significant)
//   out_valid/ready: operand handshake
//   overflow       : sticky, a digit was dropped on a full register
//   bad_char       : one-cycle pulse on an accepted illegal character
// Optional: define DISP2BCD_ENTRY_ECHO_EN to add echo_char/echo_valid, which
// mirror each accepted character that changed the operand, plus CR and ESC.
module disp2bcd_entry
   import lcd_chars_pkg::*;
#(
   parameter  int unsigned DIGITS = 10,
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             char_ready,
   output logic [3:0]       bcd [DIGITS-1:0],
   output logic             sign,
   output logic [CNT_W-1:0] count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             bad_char
`ifdef DISP2BCD_ENTRY_ECHO_EN
   ,
   output logic [7:0]       echo_char,
   output logic             echo_valid
`endif
);

   entry_state_t state;
   char_class_t  char_cls_c;
   logic [3:0]   digit_c;
   logic         accept_c;
   logic         clear_c;
   logic         echo_c;

   disp_char_classify u_classify (
      .char_in    (char_in),
      .char_cls_c (char_cls_c),
      .digit_c    (digit_c)
   );

   // Ready is a pure decode of the state register.
   assign char_ready = (state != HOLD);
   assign accept_c   = char_valid && char_ready;
   // Handshake completion and ESC both return every field to its reset value.
   assign clear_c    = (out_valid && out_ready) || (accept_c && (char_cls_c == CLS_ESC));

   // Characters that get mirrored to the display when accepted.
   always_comb begin
      echo_c = 1'b0;
      if (accept_c) begin
         case (char_cls_c)
            CLS_DIGIT: echo_c = !((count == '0) && (digit_c == 4'd0)) &&
                                (count < CNT_W'(DIGITS));
            CLS_MINUS: echo_c = (count == '0);
            CLS_BS:    echo_c = (count != '0);
            CLS_ESC:   echo_c = 1'b1;
            CLS_ENTER: echo_c = 1'b1;
            default:   echo_c = 1'b0;
         endcase
      end
   end

   // Entry FSM and digit shift register.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_c) begin
         for (int i = 0; i < DIGITS; i++) bcd[i] <= 4'd0;
         sign      <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         bad_char  <= 1'b0;
         state     <= IDLE;
      end else begin
         bad_char <= 1'b0;
         if (accept_c) begin
            case (char_cls_c)
               CLS_DIGIT: begin
                  if ((count == '0) && (digit_c == 4'd0)) begin
                     state <= ENTRY;
                  end else if (count < CNT_W'(DIGITS)) begin
                     for (int i = DIGITS - 1; i > 0; i--) bcd[i] <= bcd[i-1];
                     bcd[0] <= digit_c;
                     count  <= count + CNT_W'(1);
                     state  <= ENTRY;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               CLS_MINUS: begin
                  if (count == '0) begin
                     sign  <= ~sign;
                     state <= ENTRY;
                  end else begin
                     bad_char <= 1'b1;
                  end
               end
               CLS_BS: begin
                  if (count != '0) begin
                     for (int i = 0; i < DIGITS - 1; i++) bcd[i] <= bcd[i+1];
                     bcd[DIGITS-1] <= 4'd0;
                     count    <= count - CNT_W'(1);
                     overflow <= 1'b0;
                  end else begin
                     sign  <= 1'b0;
                     state <= IDLE;
                  end
               end
               CLS_ENTER: begin
                  // Never present negative zero.
                  if (count == '0) sign <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
               CLS_BLANK: ;
               default:   bad_char <= 1'b1;
            endcase
         end
      end
   end

`ifdef DISP2BCD_ENTRY_ECHO_EN
   // Echo register, one cycle behind the accepting edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         echo_char  <= 8'h00;
         echo_valid <= 1'b0;
      end else begin
         echo_valid <= echo_c;
         if (echo_c) echo_char <= char_in;
      end
   end
`else
   logic unused_echo;
   assign unused_echo = echo_c;
`endif

endmodule

// File: tb/tb_disp2bcd_entry.sv
// tb_disp2bcd_entry: directed scenarios plus randomized keystrokes, checked
// against a queue-based model of the operand being typed.
module tb_disp2bcd_entry;
   import lcd_chars_pkg::*;

   localparam int unsigned DIGITS = 10;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned VW     = 4 * DIGITS + CNT_W + 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       char_in = 8'h00;
   logic             char_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             char_ready;
   logic [3:0]       bcd [DIGITS-1:0];
   logic             sign;
   logic [CNT_W-1:0] count;
   logic             out_valid;
   logic             overflow;
   logic             bad_char;
`ifdef DISP2BCD_ENTRY_ECHO_EN
   logic [7:0]       echo_char;
   logic             echo_valid;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   disp2bcd_entry #(.DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .bcd        (bcd),
      .sign       (sign),
      .count      (count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .bad_char   (bad_char)
`ifdef DISP2BCD_ENTRY_ECHO_EN
      ,
      .echo_char  (echo_char),
      .echo_valid (echo_valid)
`endif
   );

   // Reference model: digits typed so far, q[0] is the least significant.
   int         q[$];
   bit         m_sign, m_ovf, m_bad, m_echo_v;
   int         m_phase;   // 0 empty, 1 typing, 2 presented
   logic [7:0] m_echo_c;

   logic [VW-1:0] dut_vec;
   always_comb begin
      dut_vec = '0;
      for (int i = 0; i < DIGITS; i++) dut_vec[4*i +: 4] = bcd[i];
      dut_vec[4*DIGITS +: CNT_W] = count;
      dut_vec[VW-4] = sign;
      dut_vec[VW-3] = overflow;
      dut_vec[VW-2] = out_valid;
      dut_vec[VW-1] = char_ready;
   end

   function automatic logic [VW-1:0] exp_vec();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < q.size(); i++) v[4*i +: 4] = 4'(q[i]);
      v[4*DIGITS +: CNT_W] = CNT_W'(q.size());
      v[VW-4] = m_sign;
      v[VW-3] = m_ovf;
      v[VW-2] = (m_phase == 2);
      v[VW-1] = (m_phase != 2);
      return v;
   endfunction

   task automatic model_clear();
      q.delete();
      m_sign  = 1'b0;
      m_ovf   = 1'b0;
      m_phase = 0;
   endtask

   task automatic model_char(input logic [7:0] c);
      int d;
      if (c >= 8'h30 && c <= 8'h39) begin
         d = int'(c) - 48;
         if (q.size() == 0 && d == 0) m_phase = 1;
         else if (q.size() < DIGITS) begin
            q.push_front(d);
            m_phase = 1;
            m_echo_v = 1'b1;
         end else m_ovf = 1'b1;
      end else if (c == 8'h2D) begin
         if (q.size() == 0) begin
            m_sign = ~m_sign;
            m_phase = 1;
            m_echo_v = 1'b1;
         end else m_bad = 1'b1;
      end else if (c == 8'h08) begin
         if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
            m_echo_v = 1'b1;
         end else begin
            m_sign = 1'b0;
            m_phase = 0;
         end
      end else if (c == 8'h1B) begin
         model_clear();
         m_echo_v = 1'b1;
      end else if (c == 8'h0D) begin
         if (q.size() == 0) m_sign = 1'b0;
         m_phase = 2;
         m_echo_v = 1'b1;
      end else if (c != 8'h20) begin
         m_bad = 1'b1;
      end
      if (m_echo_v) m_echo_c = c;
   endtask

   // Drive one cycle of inputs (from a negedge), advance the model on the
   // rising edge, and return at the following negedge.
   task automatic cycle(input logic v, input logic [7:0] c, input logic rdy);
      char_valid = v;
      char_in    = c;
      out_ready  = rdy;
      @(posedge clk);
      m_bad    = 1'b0;
      m_echo_v = 1'b0;
      if (!rst_n) model_clear();
      else if (m_phase == 2) begin
         if (out_ready) model_clear();
      end else if (char_valid) model_char(char_in);
      @(negedge clk);
   endtask

   task automatic key(input logic [7:0] c);
      cycle(1'b1, c, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++; $display("FAIL reset_state got %h exp %h", dut_vec, exp_vec());
      end
      checks++;
      if (out_valid !== 1'b0 || bad_char !== 1'b0 || char_ready !== 1'b1) begin
         errors++; $display("FAIL reset_flags got %b%b%b exp 001", out_valid, bad_char, char_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] k [4] = '{8'h31, 8'h32, 8'h33, 8'h0D};
      for (int i = 0; i < 4; i++) key(k[i]);
      checks++;
      if (count !== 4'd3 || bcd[2] !== 4'd1 || bcd[1] !== 4'd2 || bcd[0] !== 4'd3 || sign !== 1'b0) begin
         errors++; $display("FAIL basic_operand got cnt %0d %0d%0d%0d s%b exp cnt 3 123 s0",
                            count, bcd[2], bcd[1], bcd[0], sign);
      end
      // Held for five cycles; a character offered meanwhile must be refused.
      for (int i = 0; i < 5; i++) begin
         cycle(i == 2, 8'h35, 1'b0);
         checks++;
         if (dut_vec !== exp_vec() || out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_hold got %h exp %h", dut_vec, exp_vec());
         end
      end
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (dut_vec !== exp_vec() || char_ready !== 1'b1 || count !== 4'd0) begin
         errors++; $display("FAIL basic_release got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_leading_zero();
      logic [7:0] k [5] = '{8'h2D, 8'h30, 8'h30, 8'h37, 8'h0D};
      for (int i = 0; i < 5; i++) key(k[i]);
      checks++;
      if (bcd[0] !== 4'd7 || count !== 4'd1 || sign !== 1'b1 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL leading_zero got %h exp %h", dut_vec, exp_vec());
      end
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_overflow();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 11; i++) key(8'h39);
         if (pass == 1) key(8'h08);
         key(8'h0D);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL overflow_%0d got %h exp %h", pass, dut_vec, exp_vec());
         end
         checks++;
         if (count !== ((pass == 0) ? 4'd10 : 4'd9) || overflow !== (pass == 0)) begin
            errors++; $display("FAIL overflow_flag_%0d got cnt %0d ovf %b", pass, count, overflow);
         end
         cycle(1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic test_bad_char();
      logic [7:0] k [3] = '{8'h34, 8'h2D, 8'h41};
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         key(k[i]);
         checks++;
         if (bad_char !== m_bad) begin
            errors++; $display("FAIL bad_char_%0d got %b exp %b", i, bad_char, m_bad);
         end
         if (bad_char === 1'b1) pulses++;
      end
      cycle(1'b0, 8'h00, 1'b0);
      if (bad_char === 1'b1) pulses++;
      checks++;
      if (pulses != 2 || bcd[0] !== 4'd4 || sign !== 1'b0 || count !== 4'd1) begin
         errors++; $display("FAIL bad_char_result got pulses %0d d0 %0d s%b exp 2 4 0", pulses, bcd[0], sign);
      end
      key(8'h1B);
   endtask

   task automatic test_neg_zero_and_escape();
      key(8'h2D);
      key(8'h0D);
      checks++;
      if (out_valid !== 1'b1 || count !== 4'd0 || sign !== 1'b0) begin
         errors++; $display("FAIL neg_zero got v%b cnt %0d s%b exp v1 cnt 0 s0", out_valid, count, sign);
      end
      cycle(1'b0, 8'h00, 1'b1);
      key(8'h35);
      key(8'h1B);
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (dut_vec !== exp_vec() || out_valid !== 1'b0 || count !== 4'd0) begin
         errors++; $display("FAIL escape got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      key(8'h31); key(8'h32);
      rst_n = 1'b0; cycle(1'b0, 8'h00, 1'b0); rst_n = 1'b1;
      checks++;
      if (dut_vec !== exp_vec() || count !== 4'd0 || bcd[0] !== 4'd0) begin
         errors++; $display("FAIL reset_entry got %h exp %h", dut_vec, exp_vec());
      end
      key(8'h33); key(8'h0D);
      rst_n = 1'b0; cycle(1'b0, 8'h00, 1'b0); rst_n = 1'b1;
      checks++;
      if (dut_vec !== exp_vec() || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_hold got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [16] = '{8'h30, 8'h31, 8'h32, 8'h35, 8'h39, 8'h37, 8'h2D, 8'h08,
                                8'h08, 8'h1B, 8'h20, 8'h0D, 8'h41, 8'h2A, 8'h33, 8'h36};
      logic [7:0] c;
      for (int n = 0; n < 800; n++) begin
         c = pool[$urandom_range(0, 15)];
         if ($urandom_range(0, 31) == 0) c = 8'($urandom());
         // Keep the 0-9 weighting high enough to reach overflow sometimes.
         if ($urandom_range(0, 3) == 0) c = 8'h39;
         rst_n = ($urandom_range(0, 199) != 0);
         cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 3) == 0);
         rst_n = 1'b1;
         checks++;
         if (dut_vec !== exp_vec() || bad_char !== m_bad) begin
            errors++; $display("FAIL random_%0d got %h/%b exp %h/%b", n, dut_vec, bad_char, exp_vec(), m_bad);
         end
`ifdef DISP2BCD_ENTRY_ECHO_EN
         checks++;
         if (echo_valid !== m_echo_v || (m_echo_v && echo_char !== m_echo_c)) begin
            errors++; $display("FAIL random_echo_%0d got %b/%h exp %b/%h", n, echo_valid, echo_char, m_echo_v, m_echo_c);
         end
`endif
      end
   endtask

`ifdef DISP2BCD_ENTRY_ECHO_EN
   task automatic test_echo();
      int pulses = 0;
      key(8'h1B);
      key(8'h33);
      if (echo_valid === 1'b1) pulses++;
      checks++;
      if (echo_valid !== 1'b1 || echo_char !== 8'h33) begin
         errors++; $display("FAIL echo_digit got %b/%h exp 1/33", echo_valid, echo_char);
      end
      key(8'h58);
      if (echo_valid === 1'b1) pulses++;
      cycle(1'b0, 8'h00, 1'b0);
      if (echo_valid === 1'b1) pulses++;
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL echo_count got %0d exp 1", pulses);
      end
      key(8'h1B);
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_leading_zero();
      test_overflow();
      test_bad_char();
      test_neg_zero_and_escape();
      test_reset_mid();
`ifdef DISP2BCD_ENTRY_ECHO_EN
      test_echo();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
